alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU in the datapath.
- Operands and opcode are latched on a start/done handshake.
- Arithmetic and logic ops complete in 1 cycle; shifts and rotates execute iteratively, 1 bit per cycle, with the last shifted-out bit captured in carryOut.
- Result and a full flag set (C, Z, N, V) are held stable until the next operation completes; sits between the register file and the writeback mux.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), width of shiftCount.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- operation  input  4  opcode, sampled with start
- inputA  input  WIDTH  operand A / shift source
- inputB  input  WIDTH  operand B
- carryIn  input  1  carry/borrow in, sampled with start
- shiftCount  input  SHW  shift/rotate amount, sampled with start
- busy  output  1  high from the accepting edge until done
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  registered result
- carryOut  output  1  registered carry flag
- zero  output  1  registered, result==0
- negative  output  1  registered, result[WIDTH-1]
- overflow  output  1  registered signed overflow

Behaviour:
- Reset: clk and rst as named above; one clock; reset is synchronous and active-high. On reset, all outputs are 0 and the FSM returns to IDLE. Reset asserted mid-operation aborts it: no done, outputs cleared.
- FSM states: IDLE, EXEC, SHIFT, DONE.
  - IDLE: start=1 latches all inputs. Goes to EXEC for non-shift ops; goes to SHIFT for shift ops with shiftCount>0; goes to EXEC for shift ops with shiftCount=0.
  - EXEC: computes and registers result and flags, then goes to DONE.
  - SHIFT: 1 bit per cycle, count decrements; after the last bit, registers flags and goes to DONE.
  - DONE: done=1 for this cycle only, busy=0, then returns to IDLE. A start arriving in the DONE cycle is accepted.
- Latency, with start accepted at edge t:
  - Non-shift ops: done high after edge t+2.
  - Shifts: done high after edge t+n+2 (n=shiftCount), busy high across that span.
- start while busy=1 is ignored; latched operands must not change.
- Opcodes (C = carryOut):
  - 1000 ADD: {C,R}=A+B.
  - 1001 ADC: {C,R}=A+B+carryIn.
  - 1010 SUB: {C,R}=A-B; C=1 means borrow.
  - 1011 SBC: {C,R}=A-B-carryIn.
  - 1100 AND, 1101 OR, 1110 XOR: C=0.
  - 1111 ANDN: R=A&~B, C=0.
  - 0000 SHL: zero fill; C=last bit out of MSB.
  - 0001 SHR: logical, zero fill; C=last bit out of LSB.
  - 0010 ROL, 0011 ROR: C=last bit rotated across the end.
  - 01xx reserved: R=A, C=0, V=0; completes via EXEC.
- Shifts always operate on inputA.
- shiftCount=0: R=A, C=0.
- Arithmetic is computed at WIDTH+1 bits; the extra bit is C.
- V is set on signed overflow of ADD/ADC (same-sign operands, result sign differs) and SUB/SBC (opposite-sign operands, result sign differs from A); V=0 for all other ops.
- Z=(R==0) and N=R[WIDTH-1] for every op.
- result and flags update only on the completing edge and hold until the next completion or reset; partial shift values are never visible on result.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: shifts and rotates use a combinational barrel shifter and follow the EXEC path, so done comes after edge t+2 regardless of shiftCount; the SHIFT state is not built. Results and flags are identical to the iterative path.
- Undefined: iterative SHIFT path as specified above.

Test Plan (WIDTH=8):
- ADD A=0xFF, B=0x01 -> result 0x00, C=1, Z=1, N=0, V=0; done one cycle after EXEC; busy low in DONE.
- SUB A=0x80, B=0x01 -> result 0x7F, C=0, V=1, N=0; SBC A=0x00, B=0x00, carryIn=1 -> result 0xFF, C=1, N=1.
- ROL A=0x81, shiftCount=3 -> result 0x0C, C=0, busy for 3 SHIFT cycles plus DONE; SHR A=0x05, shiftCount=1 -> result 0x02, C=1; SHL A=0x40, shiftCount=0 -> result 0x40, C=0 via EXEC.
- ANDN A=0xF0, B=0x3C -> result 0xC0, C=0, V=0; reserved opcode 0100, A=0x5A -> result 0x5A.
- Start ROR A=0x01, shiftCount=7, then pulse start with ADD during busy -> ADD ignored; result 0x02, C=0; next start in the DONE cycle accepted.
- Start SHL A=0xFF, shiftCount=5, assert rst at the 2nd SHIFT cycle -> no done; all outputs 0 on the next edge; IDLE accepts start on the following cycle. Repeat the suite with ALU_BARREL_SHIFT_EN defined: identical values, constant shift latency.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with a start/done handshake. Shifts and rotates
// run iteratively (1 bit/cycle) unless ALU_BARREL_SHIFT_EN selects a barrel shifter.
module alu_seq_unit #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             carryIn,
  input  logic [SHW-1:0]   shiftCount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_SHL  = 4'b0000;
  localparam logic [3:0] OP_SHR  = 4'b0001;
  localparam logic [3:0] OP_ROL  = 4'b0010;
  localparam logic [3:0] OP_ROR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_ADC  = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_SBC  = 4'b1011;
  localparam logic [3:0] OP_AND  = 4'b1100;
  localparam logic [3:0] OP_OR   = 4'b1101;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_ANDN = 4'b1111;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t           state_r, nextState_s;
  logic [3:0]       opcode_r;
  logic [WIDTH-1:0] opA_r, opB_r;
  logic             carryIn_r;
  logic [SHW-1:0]   count_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r, zero_r, neg_r, ovf_r, busy_r, done_r;
  logic             accept_s;
  logic [WIDTH:0]   execSum_s;
  logic             execV_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

`ifdef ALU_BARREL_SHIFT_EN
  logic [WIDTH-1:0] rotL_s, rotR_s;
  logic [WIDTH:0]   shrTmp_s;

  // Barrel shifter: rotate in power-of-two stages so any count wraps correctly
  always_comb begin
    rotL_s = opA_r;
    rotR_s = opA_r;
    for (int i = 0; i < SHW; i++) begin
      rotL_s = count_r[i] ? ((rotL_s << ((1 << i) % WIDTH)) | (rotL_s >> (WIDTH - ((1 << i) % WIDTH))))
                          : rotL_s;
      rotR_s = count_r[i] ? ((rotR_s >> ((1 << i) % WIDTH)) | (rotR_s << (WIDTH - ((1 << i) % WIDTH))))
                          : rotR_s;
    end
    shrTmp_s = {opA_r, 1'b0} >> count_r;
  end
`else
  logic [WIDTH-1:0] work_r;
  logic             workC_r;
  logic             goShift_s;

  assign goShift_s = (operation[3:2] == 2'b00) && (shiftCount != {SHW{1'b0}});

  // One iterative step; returns {bit shifted out, new value}
  function automatic logic [WIDTH:0] shiftOne(input logic [3:0] op, input logic [WIDTH-1:0] val);
    logic [WIDTH:0] res;
    case (op)
      OP_SHL:  res = {val[MSB], val[MSB-1:0], 1'b0};
      OP_SHR:  res = {val[0], 1'b0, val[MSB:1]};
      OP_ROL:  res = {val[MSB], val[MSB-1:0], val[MSB]};
      OP_ROR:  res = {val[0], val[0], val[MSB:1]};
      default: res = {1'b0, val};
    endcase
    return res;
  endfunction
`endif

  // Single-cycle datapath on latched operands; execSum_s is {carry, result}
  always_comb begin
    execSum_s = {1'b0, opA_r};
    execV_s   = 1'b0;
    case (opcode_r)
      OP_ADD: begin
        execSum_s = {1'b0, opA_r} + {1'b0, opB_r};
        execV_s   = (opA_r[MSB] == opB_r[MSB]) && (execSum_s[MSB] != opA_r[MSB]);
      end
      OP_ADC: begin
        execSum_s = {1'b0, opA_r} + {1'b0, opB_r} + {{WIDTH{1'b0}}, carryIn_r};
        execV_s   = (opA_r[MSB] == opB_r[MSB]) && (execSum_s[MSB] != opA_r[MSB]);
      end
      OP_SUB: begin
        execSum_s = {1'b0, opA_r} - {1'b0, opB_r};
        execV_s   = (opA_r[MSB] != opB_r[MSB]) && (execSum_s[MSB] != opA_r[MSB]);
      end
      OP_SBC: begin
        execSum_s = {1'b0, opA_r} - {1'b0, opB_r} - {{WIDTH{1'b0}}, carryIn_r};
        execV_s   = (opA_r[MSB] != opB_r[MSB]) && (execSum_s[MSB] != opA_r[MSB]);
      end
      OP_AND:  execSum_s = {1'b0, opA_r & opB_r};
      OP_OR:   execSum_s = {1'b0, opA_r | opB_r};
      OP_XOR:  execSum_s = {1'b0, opA_r ^ opB_r};
      OP_ANDN: execSum_s = {1'b0, opA_r & ~opB_r};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SHL:  execSum_s = {1'b0, opA_r} << count_r;
      OP_SHR:  execSum_s = {shrTmp_s[0], shrTmp_s[WIDTH:1]};
      OP_ROL:  execSum_s = {(count_r != {SHW{1'b0}}) & rotL_s[0], rotL_s};
      OP_ROR:  execSum_s = {(count_r != {SHW{1'b0}}) & rotR_s[MSB], rotR_s};
`endif
      default: execSum_s = {1'b0, opA_r};
    endcase
  end

  // Next-state logic; DONE behaves like IDLE so back-to-back starts are taken
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
`ifdef ALU_BARREL_SHIFT_EN
          nextState_s = EXEC;
`else
          nextState_s = goShift_s ? SHIFT : EXEC;
`endif
        end else begin
          nextState_s = IDLE;
        end
      end
      EXEC: nextState_s = DONE;
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: nextState_s = (count_r == {SHW{1'b0}}) ? DONE : SHIFT;
`endif
      default: nextState_s = IDLE;
    endcase
  end

  // State, operand latches, shift working register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      opcode_r  <= 4'b0000;
      opA_r     <= {WIDTH{1'b0}};
      opB_r     <= {WIDTH{1'b0}};
      carryIn_r <= 1'b0;
      count_r   <= {SHW{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      zero_r    <= 1'b0;
      neg_r     <= 1'b0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      work_r    <= {WIDTH{1'b0}};
      workC_r   <= 1'b0;
`endif
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE) && (nextState_s != DONE);
      done_r  <= (nextState_s == DONE);
      if (accept_s) begin
        opcode_r  <= operation;
        opA_r     <= inputA;
        opB_r     <= inputB;
        carryIn_r <= carryIn;
        count_r   <= shiftCount;
`ifndef ALU_BARREL_SHIFT_EN
        work_r    <= inputA;
        workC_r   <= 1'b0;
`endif
      end
      if (state_r == EXEC) begin
        result_r <= execSum_s[MSB:0];
        carry_r  <= execSum_s[WIDTH];
        zero_r   <= (execSum_s[MSB:0] == {WIDTH{1'b0}});
        neg_r    <= execSum_s[MSB];
        ovf_r    <= execV_s;
      end
`ifndef ALU_BARREL_SHIFT_EN
      // Partial values stay in work_r; result only changes on the final cycle
      if (state_r == SHIFT) begin
        if (count_r != {SHW{1'b0}}) begin
          {workC_r, work_r} <= shiftOne(opcode_r, work_r);
          count_r           <= count_r - {{(SHW-1){1'b0}}, 1'b1};
        end else begin
          result_r <= work_r;
          carry_r  <= workC_r;
          zero_r   <= (work_r == {WIDTH{1'b0}});
          neg_r    <= work_r[MSB];
          ovf_r    <= 1'b0;
        end
      end
`endif
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign carryOut = carry_r;
  assign zero     = zero_r;
  assign negative = neg_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=8); shift latency
// expectations follow ALU_BARREL_SHIFT_EN when it is defined.
`timescale 1ns/1ps
module tb_alu_seq_unit;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] inputA, inputB;
  logic             carryIn;
  logic [SHW-1:0]   shiftCount;
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic             carryOut, zero, negative, overflow;

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .inputA(inputA), .inputB(inputB), .carryIn(carryIn), .shiftCount(shiftCount),
    .busy(busy), .done(done), .result(result), .carryOut(carryOut),
    .zero(zero), .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift completion position, counted in falling edges after the accepting edge
  function automatic int shLat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
    return 2;
`else
    return n + 2;
`endif
  endfunction

  // Called at a falling edge; returns at the first falling edge after acceptance
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [2:0] sc);
    operation = op; inputA = a; inputB = b; carryIn = ci; shiftCount = sc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int kStart, input int expK);
    int k;
    k = kStart;
    while (done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, expK);
    check({tag, " busyInDone"}, busy, 1'b0);
  endtask

  // expF is {C, Z, N, V}
  task automatic runOp(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [2:0] sc,
                       input int expK, input logic [7:0] expR, input logic [3:0] expF);
    issue(op, a, b, ci, sc);
    check({tag, " busyEarly"}, busy, 1'b1);
    waitDone(tag, 1, expK);
    check({tag, " result"}, result, expR);
    check({tag, " flagsCZNV"}, {carryOut, zero, negative, overflow}, expF);
    @(negedge clk);
    check({tag, " donePulse"}, done, 1'b0);
    check({tag, " hold"}, result, expR);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; operation = 4'b0000; inputA = 8'h00; inputB = 8'h00;
    carryIn = 1'b0; shiftCount = 3'd0;
    repeat (2) @(negedge clk);
    check("reset result", result, 8'h00);
    check("reset flags", {carryOut, zero, negative, overflow}, 4'b0000);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    runOp("ADD",   4'b1000, 8'hFF, 8'h01, 1'b0, 3'd0, 2,        8'h00, 4'b1100);
    runOp("SUBv",  4'b1010, 8'h80, 8'h01, 1'b0, 3'd0, 2,        8'h7F, 4'b0001);
    runOp("SUBb",  4'b1010, 8'h01, 8'h02, 1'b0, 3'd0, 2,        8'hFF, 4'b1010);
    runOp("SBC",   4'b1011, 8'h00, 8'h00, 1'b1, 3'd0, 2,        8'hFF, 4'b1010);
    runOp("ADC",   4'b1001, 8'h7F, 8'h00, 1'b1, 3'd0, 2,        8'h80, 4'b0011);
    runOp("AND",   4'b1100, 8'h0F, 8'hF0, 1'b0, 3'd0, 2,        8'h00, 4'b0100);
    runOp("ANDN",  4'b1111, 8'hF0, 8'h3C, 1'b0, 3'd0, 2,        8'hC0, 4'b0010);
    runOp("RSVD",  4'b0100, 8'h5A, 8'hFF, 1'b1, 3'd3, 2,        8'h5A, 4'b0000);
    runOp("ROL3",  4'b0010, 8'h81, 8'h00, 1'b0, 3'd3, shLat(3), 8'h0C, 4'b0000);
    runOp("SHR1",  4'b0001, 8'h05, 8'h00, 1'b0, 3'd1, shLat(1), 8'h02, 4'b1000);
    runOp("SHL0",  4'b0000, 8'h40, 8'h00, 1'b0, 3'd0, 2,        8'h40, 4'b0000);
    runOp("SHL2",  4'b0000, 8'h60, 8'h00, 1'b0, 3'd2, shLat(2), 8'h80, 4'b1010);

    // ROR with an ADD start pulsed while busy; then a start in the DONE cycle
    issue(4'b0011, 8'h01, 8'h00, 1'b0, 3'd7);
    check("ROR7 busyEarly", busy, 1'b1);
    operation = 4'b1000; inputA = 8'hFF; inputB = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("ROR7", 2, shLat(7));
    check("ROR7 result", result, 8'h02);
    check("ROR7 flagsCZNV", {carryOut, zero, negative, overflow}, 4'b0000);
    issue(4'b1110, 8'hA5, 8'hFF, 1'b0, 3'd0);
    check("XORinDone busyEarly", busy, 1'b1);
    check("XORinDone doneLow", done, 1'b0);
    waitDone("XORinDone", 1, 2);
    check("XORinDone result", result, 8'h5A);
    check("XORinDone flagsCZNV", {carryOut, zero, negative, overflow}, 4'b0000);
    @(negedge clk);
    check("XORinDone donePulse", done, 1'b0);

    // Reset in the middle of a long shift aborts it
    issue(4'b0000, 8'hFF, 8'h00, 1'b0, 3'd5);
    check("abort noDone1", done, 1'b0);
    check("abort noPartial1", result, 8'h5A);
`ifndef ALU_BARREL_SHIFT_EN
    @(negedge clk);
    check("abort noDone2", done, 1'b0);
    check("abort noPartial2", result, 8'h5A);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort result", result, 8'h00);
    check("abort flags", {carryOut, zero, negative, overflow}, 4'b0000);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    runOp("postRst ADD", 4'b1000, 8'h12, 8'h34, 1'b0, 3'd0, 2, 8'h46, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
